// File: rtl/puf_challenge_driver.sv
// RO-PUF challenge initiator: steps through the 4 challenges, times each
// measurement window, samples synchronized counters and returns resp/tie_mask.
module puf_challenge_driver #(
  parameter int unsigned WIN_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             puf_en,
  output logic             puf_rst,
  output logic [1:0]       puf_sel,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic [3:0]       resp,
  output logic [3:0]       tie_mask,
  output logic             resp_valid,
  input  logic             resp_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [15:0] CLR_LAST = 16'd1;
  localparam logic [15:0] RUN_LAST = 16'(WIN_CYCLES - 1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [1:0]       ch_q, ch_d;
  logic [3:0]       resp_q, resp_d;
  logic [3:0]       tie_q, tie_d;
  logic [CNT_W-1:0] cnt_a_meta_q, cnt_a_meta_d, cnt_a_sync_q, cnt_a_sync_d;
  logic [CNT_W-1:0] cnt_b_meta_q, cnt_b_meta_d, cnt_b_sync_q, cnt_b_sync_d;

  // Two-flop synchronizers for the counters crossing in from the ring oscillators.
  always_comb begin
    cnt_a_meta_d = cnt_a;
    cnt_a_sync_d = cnt_a_meta_q;
    cnt_b_meta_d = cnt_b;
    cnt_b_sync_d = cnt_b_meta_q;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ch_d    = ch_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      timer_d = 16'd0;
      ch_d    = 2'd0;
      resp_d  = 4'd0;
      tie_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_CLEAR;
            timer_d = 16'd0;
            ch_d    = 2'd0;
            resp_d  = 4'd0;
            tie_d   = 4'd0;
          end
        end
        S_CLEAR: begin
          if (timer_q == CLR_LAST) begin
            state_d = S_RUN;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_RUN: begin
          if (timer_q == RUN_LAST) begin
            state_d = S_SETTLE;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_SETTLE: begin
          if (timer_q == SET_LAST) begin
            state_d = S_SAMPLE;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_SAMPLE: begin
          // A tie yields resp=0 naturally since the compare is strict.
          resp_d[ch_q] = (cnt_b_sync_q > cnt_a_sync_q);
          tie_d[ch_q]  = (cnt_b_sync_q == cnt_a_sync_q);
          if (ch_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          if (resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= 16'd0;
      ch_q         <= 2'd0;
      resp_q       <= 4'd0;
      tie_q        <= 4'd0;
      cnt_a_meta_q <= '0;
      cnt_a_sync_q <= '0;
      cnt_b_meta_q <= '0;
      cnt_b_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ch_q         <= ch_d;
      resp_q       <= resp_d;
      tie_q        <= tie_d;
      cnt_a_meta_q <= cnt_a_meta_d;
      cnt_a_sync_q <= cnt_a_sync_d;
      cnt_b_meta_q <= cnt_b_meta_d;
      cnt_b_sync_q <= cnt_b_sync_d;
    end
  end

  // Outputs decode straight from the state so an async reset drops puf_en at once.
  always_comb begin
    busy       = (state_q != S_IDLE);
    puf_en     = (state_q == S_RUN);
    puf_rst    = (state_q == S_IDLE) || (state_q == S_CLEAR) || (state_q == S_DONE);
    puf_sel    = ch_q;
    resp       = resp_q;
    tie_mask   = tie_q;
    resp_valid = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Directed + randomized bench for puf_challenge_driver with a behavioural
// ring-oscillator counter model and a rule-level expectation of resp/tie_mask.
module tb_puf_challenge_driver;
  localparam int WIN = 8;
  localparam int SET = 3;
  localparam int LAT = 4 * (3 + WIN + SET);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       resp_ready = 1'b0;
  logic       busy, puf_en, puf_rst, resp_valid;
  logic [1:0] puf_sel;
  logic [3:0] cnt_a = 4'd0;
  logic [3:0] cnt_b = 4'd0;
  logic [3:0] resp, tie_mask;

  int checks = 0;
  int failures = 0;
  int k = 0;
  logic [3:0] tgt_a [4];
  logic [3:0] tgt_b [4];

  always #5 clk = ~clk;

  puf_challenge_driver #(.WIN_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy),
    .puf_en(puf_en), .puf_rst(puf_rst), .puf_sel(puf_sel), .cnt_a(cnt_a),
    .cnt_b(cnt_b), .resp(resp), .tie_mask(tie_mask), .resp_valid(resp_valid),
    .resp_ready(resp_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counters clear while puf_rst is high and ramp linearly to their target
  // over the enable window, then hold.
  task automatic model_update();
    if (puf_rst === 1'b1) begin
      k = 0;
      cnt_a = 4'd0;
      cnt_b = 4'd0;
    end else if (puf_en === 1'b1) begin
      k++;
      cnt_a = 4'((int'(tgt_a[puf_sel]) * k) / WIN);
      cnt_b = 4'((int'(tgt_b[puf_sel]) * k) / WIN);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  function automatic logic [3:0] exp_resp();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (tgt_b[i] > tgt_a[i]);
    return r;
  endfunction

  function automatic logic [3:0] exp_tie();
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = (tgt_b[i] == tgt_a[i]);
    return t;
  endfunction

  task automatic randomize_targets();
    for (int i = 0; i < 4; i++) begin
      tgt_a[i] = 4'($urandom_range(0, 15));
      tgt_b[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic measure(input string tag, input int bp);
    int n;
    int cur;
    bit seen;
    bit sel_bad;
    logic prev_en;
    logic [1:0] win_sel;
    int win_len [$];
    int sel_seq [$];
    n = 0; cur = 0; seen = 0; sel_bad = 0; prev_en = 1'b0; win_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    while (!seen && n < LAT + 20) begin
      tick();
      n++;
      if (puf_en && !prev_en) begin
        sel_seq.push_back(int'(puf_sel));
        win_sel = puf_sel;
        cur = 0;
      end
      if (puf_en) begin
        cur++;
        if (puf_sel !== win_sel) sel_bad = 1;
      end
      if (!puf_en && prev_en) win_len.push_back(cur);
      prev_en = puf_en;
      if (resp_valid === 1'b1) seen = 1;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_resp"}, resp, exp_resp());
    check({tag, "_tie"}, tie_mask, exp_tie());
    check({tag, "_windows"}, win_len.size(), 4);
    for (int i = 0; i < win_len.size(); i++) check({tag, "_win_len"}, win_len[i], WIN);
    for (int i = 0; i < sel_seq.size(); i++) check({tag, "_sel_seq"}, sel_seq[i], i);
    check({tag, "_sel_stable"}, sel_bad, 0);
    for (int i = 0; i < bp; i++) begin
      if (i % 3 == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_bp_valid"}, resp_valid, 1);
      check({tag, "_bp_resp"}, resp, exp_resp());
      check({tag, "_bp_busy"}, busy, 1);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, resp_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_resp_held"}, resp, exp_resp());
    check({tag, "_tie_held"}, tie_mask, exp_tie());
    tick();
    check({tag, "_still_idle"}, busy, 0);
  endtask

  task automatic wait_run_ch1(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (puf_en === 1'b1 && puf_sel === 2'd1) found = 1;
    end
    check({tag, "_reached_run_ch1"}, found, 1);
  endtask

  initial begin
    // Reset and idle behaviour.
    repeat (3) @(posedge clk);
    #1;
    check("rst_puf_en", puf_en, 0);
    check("rst_puf_rst", puf_rst, 1);
    reset = 1'b1;
    tick();
    check("idle_puf_rst", puf_rst, 1);
    check("idle_puf_en", puf_en, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", resp_valid, 0);
    check("idle_resp", resp, 0);
    check("idle_tie", tie_mask, 0);
    check("idle_sel", puf_sel, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_en_low", puf_en, 0);
    end

    // Full run: b>a for challenges 0 and 2, a>b for 1 and 3.
    tgt_a[0] = 4'd3;  tgt_b[0] = 4'd9;
    tgt_a[1] = 4'd12; tgt_b[1] = 4'd5;
    tgt_a[2] = 4'd1;  tgt_b[2] = 4'd14;
    tgt_a[3] = 4'd10; tgt_b[3] = 4'd8;
    check("default_exp_consistency", exp_resp(), 4'b0101);
    measure("default", 0);

    // Tie on challenge 2.
    tgt_a[0] = 4'd2; tgt_b[0] = 4'd6;
    tgt_a[1] = 4'd4; tgt_b[1] = 4'd11;
    tgt_a[2] = 4'd7; tgt_b[2] = 4'd7;
    tgt_a[3] = 4'd0; tgt_b[3] = 4'd15;
    measure("tie", 0);
    check("tie_word", resp, 4'b1011);
    check("tie_mask_word", tie_mask, 4'b0100);

    // Backpressure with ignored start pulses.
    randomize_targets();
    measure("backpressure", 10);

    // Abort together with start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle_busy", busy, 0);

    // Abort during RUN of challenge 1 after challenge 0 produced a 1.
    tgt_a[0] = 4'd1; tgt_b[0] = 4'd13;
    tgt_a[1] = 4'd9; tgt_b[1] = 4'd2;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run_ch1("abort");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_puf_en", puf_en, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", resp_valid, 0);
    check("abort_resp", resp, 0);
    check("abort_tie", tie_mask, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_valid", resp_valid, 0);
    end
    randomize_targets();
    measure("abort_rerun", 0);

    // Asynchronous reset in the middle of challenge 1's RUN.
    tgt_a[0] = 4'd0; tgt_b[0] = 4'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run_ch1("async_rst");
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_puf_en", puf_en, 0);
    check("async_rst_puf_rst", puf_rst, 1);
    check("async_rst_resp", resp, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_sel", puf_sel, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("async_rst_idle", busy, 0);

    // Randomized runs against the rule-level model.
    for (int r = 0; r < 4; r++) begin
      randomize_targets();
      measure("random", r * 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_challenge_driver.md
Name: puf_challenge_driver

Overview:
- Initiator side of the RO-PUF challenge/response interface.
- Drives the PUF core's enable, counter reset and 2-bit challenge select for each of the 4 challenges in turn.
- Times a fixed measurement window per challenge, samples both frequency counters after they settle, and forms one response bit per challenge.
- Returns the 4-bit response word, plus a tie mask, to the consumer through a valid/ready handshake.

Parameters:
- WIN_CYCLES, 8: clk cycles puf_en is held high per challenge; legal range 1..65535.
- SETTLE_CYCLES, 3: clk cycles after puf_en falls before counters are sampled; must be >= 3 to cover the input synchronizer.
- CNT_W, 4: width of each PUF counter input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one full 4-challenge measurement; sampled only in IDLE.
- abort  in  1  synchronous abort; returns FSM to IDLE.
- busy  out  1  high in every state except IDLE.
- puf_en  out  1  ring-oscillator enable to PUF core.
- puf_rst  out  1  active-high counter clear to PUF core.
- puf_sel  out  2  challenge select to PUF muxes.
- cnt_a  in  CNT_W  PUF counter for mux-1 path; asynchronous to clk.
- cnt_b  in  CNT_W  PUF counter for mux-2 path; asynchronous to clk.
- resp  out  4  response word; bit i is the result for challenge i.
- tie_mask  out  4  bit i high when the counters were equal for challenge i.
- resp_valid  out  1  resp and tie_mask valid.
- resp_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - puf_en=0, puf_rst=1, puf_sel=0, resp=0, tie_mask=0, resp_valid=0, busy=0.
  - Synchronizers and timers are cleared.
- Synchronizer: cnt_a and cnt_b each pass through a 2-flop synchronizer; all comparisons use the synchronized values.
- States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE. A single 16-bit timer serves CLEAR, RUN and SETTLE. A 2-bit challenge index ch drives puf_sel.
- IDLE:
  - puf_rst=1, puf_en=0.
  - start=1 → CLEAR, with ch=0, resp and tie_mask cleared.
- CLEAR: puf_rst=1, puf_en=0 for exactly 2 cycles, then → RUN.
- RUN: puf_rst=0, puf_en=1 for exactly WIN_CYCLES cycles, then → SETTLE.
- SETTLE: puf_en=0, puf_rst=0 for SETTLE_CYCLES cycles, then → SAMPLE.
- SAMPLE (1 cycle):
  - resp[ch] = (cnt_b_sync > cnt_a_sync), unsigned.
  - tie_mask[ch] = (cnt_b_sync == cnt_a_sync); on a tie resp[ch]=0.
  - If ch==3 → DONE; else ch increments and → CLEAR.
- puf_sel: equals ch throughout CLEAR, RUN, SETTLE and SAMPLE; changes only on the SAMPLE→CLEAR edge, never while puf_en=1.
- DONE:
  - resp_valid=1, busy=1, puf_rst=1.
  - resp and tie_mask are held stable until resp_ready=1 is seen with resp_valid=1.
  - On acceptance: resp_valid falls on the next edge, FSM → IDLE. resp and tie_mask keep their values until the next start.
- Latency: resp_valid rises exactly 4*(3+WIN_CYCLES+SETTLE_CYCLES) cycles after the edge that samples start in IDLE. With defaults this is 56.
- start while busy: ignored, no queuing.
- abort:
  - Highest priority after reset. In any non-IDLE state → IDLE next edge.
  - puf_en=0, resp_valid=0, partial resp discarded (cleared).
  - If asserted together with start in IDLE, start is ignored.
- resp_ready without resp_valid: no effect.
- Counter wrap: the PUF counters wrap modulo 2^CNT_W. Choosing WIN_CYCLES so counts do not wrap is system-level; the block compares raw values.
- Reset mid-operation: puf_en drops immediately (asynchronous), and all outputs go to their reset values.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release → puf_rst=1, puf_en=0, busy=0, resp_valid=0; puf_en stays 0 for 20 idle cycles.
- Full run with defaults: pulse start; model cnt_b>cnt_a for sel 0 and 2, cnt_a>cnt_b for sel 1 and 3 → resp_valid rises at cycle 56, resp=4'b0101, tie_mask=0; puf_en high for exactly 8 cycles per challenge, 4 windows, and puf_sel sequence 0,1,2,3.
- Tie: cnt_a=cnt_b=4'd7 for sel 2, others cnt_b>cnt_a → resp=4'b1011, tie_mask=4'b0100.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid → resp_valid, resp and busy held; start pulses during this time ignored; resp_ready=1 → resp_valid low next cycle, then IDLE.
- Abort: assert abort in RUN of challenge 1 → next cycle puf_en=0, busy=0, no resp_valid; a following start produces a fresh, correct 56-cycle run.
- Async reset mid-RUN: drop reset between edges → puf_en=0 and puf_rst=1 without waiting for a clk edge; resp=0.
